// File: rtl/pa_rvfpm.sv
// Shared types and widths for the rvfpm issue/commit scheduler.
package pa_rvfpm;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [1:0] {
    EMPTY,
    ISSUED,
    COMMITTED,
    KILLED
  } sched_state_e;

  typedef struct packed {
    sched_state_e            state;
    logic [X_ID_WIDTH-1:0]   id;
    logic [31:0]             instr;
    logic [3*XLEN-1:0]       rs;
  } sched_entry_t;

endpackage

// File: rtl/rvfpm_id_match.sv
// Age-ordered ID compare: one-hot of the oldest ISSUED slot whose ID equals id_i,
// scanning forward from the head slot.
module rvfpm_id_match #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic [DEPTH-1:0]            issued_i,
  input  logic [DEPTH*X_ID_WIDTH-1:0] ids_i,
  input  logic [$clog2(DEPTH)-1:0]    head_i,
  input  logic [X_ID_WIDTH-1:0]       id_i,
  output logic [DEPTH-1:0]            match_oh_o,
  output logic                        hit_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] eq;
  logic [AW-1:0]    slot;

  always_comb begin
    eq = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eq[i] = issued_i[i] && (ids_i[i*X_ID_WIDTH +: X_ID_WIDTH] == id_i);
    end
  end

  // Slot index wraps naturally because DEPTH is a power of two.
  always_comb begin
    match_oh_o = '0;
    hit_o      = 1'b0;
    slot       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head_i + AW'(k);
      if (!hit_o && eq[slot]) begin
        match_oh_o[slot] = 1'b1;
        hit_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfpm_commit_sched.sv
// In-order issue/commit scheduler: buffers issued instructions until commit/kill,
// then releases committed ones to the FPU in issue order and drops killed ones.
module rvfpm_commit_sched
  import pa_rvfpm::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = pa_rvfpm::X_ID_WIDTH,
  parameter int unsigned XLEN       = pa_rvfpm::XLEN
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [X_ID_WIDTH-1:0]   issue_id,
  input  logic [31:0]             issue_instr,
  input  logic [3*XLEN-1:0]       issue_rs,
  input  logic                    commit_valid,
  input  logic [X_ID_WIDTH-1:0]   commit_id,
  input  logic                    commit_kill,
  output logic                    disp_valid,
  input  logic                    disp_ready,
  output logic [X_ID_WIDTH-1:0]   disp_id,
  output logic [31:0]             disp_instr,
  output logic [3*XLEN-1:0]       disp_rs,
  output logic                    commit_err,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  sched_state_e          state_q [DEPTH];
  sched_state_e          state_d [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [31:0]           instr_q [DEPTH];
  logic [3*XLEN-1:0]     rs_q    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          commit_err_q, commit_err_d;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, issue_fire, pop, commit_new;
  sched_state_e  head_state, resolved;

  logic [DEPTH-1:0]            issued_vec;
  logic [DEPTH*X_ID_WIDTH-1:0] ids_flat;
  logic [DEPTH-1:0]            match_oh;
  logic                        match_hit;

  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign issue_ready = rst_n & ~full;
  assign issue_fire  = issue_valid & issue_ready;
  assign occupancy   = wr_ptr_q - rd_ptr_q;

  assign head_state  = state_q[rd_idx];
  assign disp_valid  = (head_state == COMMITTED);
  assign disp_id     = id_q[rd_idx];
  assign disp_instr  = instr_q[rd_idx];
  assign disp_rs     = rs_q[rd_idx];
  assign pop         = (head_state == KILLED) | (disp_valid & disp_ready);
  assign commit_err  = commit_err_q;

  assign resolved    = commit_kill ? KILLED : COMMITTED;
  // The entry being issued this cycle is always the youngest, so it only
  // takes the commit when no buffered ISSUED entry carries the same ID.
  assign commit_new  = commit_valid & ~match_hit & issue_fire & (issue_id == commit_id);

  always_comb begin
    issued_vec = '0;
    ids_flat   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      issued_vec[i]                            = (state_q[i] == ISSUED);
      ids_flat[i*X_ID_WIDTH +: X_ID_WIDTH]     = id_q[i];
    end
  end

  rvfpm_id_match #(
    .DEPTH      (DEPTH),
    .X_ID_WIDTH (X_ID_WIDTH)
  ) u_id_match (
    .issued_i   (issued_vec),
    .ids_i      (ids_flat),
    .head_i     (rd_idx),
    .id_i       (commit_id),
    .match_oh_o (match_oh),
    .hit_o      (match_hit)
  );

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
    end
    wr_ptr_d     = wr_ptr_q + PW'(issue_fire);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    commit_err_d = commit_valid & ~match_hit & ~commit_new;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pop && (rd_idx == AW'(i))) begin
        state_d[i] = EMPTY;
      end
      if (commit_valid && match_oh[i]) begin
        state_d[i] = resolved;
      end
      if (issue_fire && (wr_idx == AW'(i))) begin
        state_d[i] = commit_new ? resolved : ISSUED;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[i] <= EMPTY;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_err_q <= commit_err_d;
    end
  end

  // Payload is qualified by the entry state, so it needs no reset.
  always_ff @(posedge ck) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (issue_fire && (wr_idx == AW'(i))) begin
        id_q[i]    <= issue_id;
        instr_q[i] <= issue_instr;
        rs_q[i]    <= issue_rs;
      end
    end
  end

endmodule

// File: tb/tb_rvfpm_commit_sched.sv
// Self-checking bench for rvfpm_commit_sched: vector table plus directed
// full/wrap/reset sequences, with a dispatch-order scoreboard.
module tb_rvfpm_commit_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NV    = 35;

  logic            ck = 1'b0;
  logic            rst_n;
  logic            issue_valid, issue_ready;
  logic [IDW-1:0]  issue_id;
  logic [31:0]     issue_instr;
  logic [3*XLEN-1:0] issue_rs;
  logic            commit_valid, commit_kill;
  logic [IDW-1:0]  commit_id;
  logic            disp_valid, disp_ready;
  logic [IDW-1:0]  disp_id;
  logic [31:0]     disp_instr;
  logic [3*XLEN-1:0] disp_rs;
  logic            commit_err;
  logic [2:0]      occupancy;

  typedef struct {
    logic [IDW-1:0]    id;
    logic [31:0]       instr;
    logic [3*XLEN-1:0] rs;
  } exp_t;

  typedef struct {
    logic iv; logic [IDW-1:0] iid;
    logic cv; logic [IDW-1:0] cid; logic k;
    logic dr; logic push;
    logic e_rdy; logic e_dv; logic [IDW-1:0] e_did; logic e_err; logic [2:0] e_occ;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq   = 0;

  always #5 ck = ~ck;

  rvfpm_commit_sched #(
    .DEPTH      (DEPTH),
    .X_ID_WIDTH (IDW),
    .XLEN       (XLEN)
  ) dut (
    .ck           (ck),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_id     (issue_id),
    .issue_instr  (issue_instr),
    .issue_rs     (issue_rs),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_id      (disp_id),
    .disp_instr   (disp_instr),
    .disp_rs      (disp_rs),
    .commit_err   (commit_err),
    .occupancy    (occupancy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk_instr(input int s, input logic [IDW-1:0] id);
    logic [7:0] sb;
    sb = 8'(s);
    return {16'hF00D, sb, 4'h0, id};
  endfunction

  function automatic logic [3*XLEN-1:0] mk_rs(input int s, input logic [IDW-1:0] id);
    logic [19:0] sw;
    sw = 20'(s);
    return {8'hCC, sw, id, 8'hBB, sw, id, 8'hAA, sw, id};
  endfunction

  function automatic vec_t r(input int iv, input int iid, input int cv, input int cid,
                             input int k, input int dr, input int push, input int e_rdy,
                             input int e_dv, input int e_did, input int e_err, input int e_occ);
    vec_t v;
    v.iv = 1'(iv); v.iid = 4'(iid); v.cv = 1'(cv); v.cid = 4'(cid); v.k = 1'(k);
    v.dr = 1'(dr); v.push = 1'(push); v.e_rdy = 1'(e_rdy); v.e_dv = 1'(e_dv);
    v.e_did = 4'(e_did); v.e_err = 1'(e_err); v.e_occ = 3'(e_occ);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs (called at negedge) and services the scoreboard.
  task automatic drive(input logic iv, input logic [IDW-1:0] iid, input logic cv,
                       input logic [IDW-1:0] cid, input logic k, input logic dr,
                       input logic push);
    exp_t e;
    issue_valid  = iv;
    issue_id     = iid;
    issue_instr  = mk_instr(seq, iid);
    issue_rs     = mk_rs(seq, iid);
    commit_valid = cv;
    commit_id    = cid;
    commit_kill  = k;
    disp_ready   = dr;
    if (iv && push) begin
      e.id    = iid;
      e.instr = mk_instr(seq, iid);
      e.rs    = mk_rs(seq, iid);
      sbq.push_back(e);
    end
    if (iv) seq++;
    #1;
    if (disp_valid && disp_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dispatch: got id %0d, expected no dispatch", disp_id);
      end else begin
        e = sbq.pop_front();
        chk("disp_id", 128'(disp_id), 128'(e.id));
        chk("disp_instr", 128'(disp_instr), 128'(e.instr));
        chk("disp_rs", 128'(disp_rs), 128'(e.rs));
      end
    end
  endtask

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && occupancy != 3'd0; c++) begin
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk(name, 128'(occupancy), 128'd0);
  endtask

  initial begin
    //            iv id cv cid k dr push | rdy dv did err occ
    tbl[0]  = r(1, 3, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    tbl[1]  = r(0, 0, 1, 3, 0, 1, 0,   1, 0, 0, 0, 1);
    tbl[2]  = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 3, 0, 1);
    tbl[3]  = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[4]  = r(1, 1, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
    tbl[5]  = r(1, 2, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1);
    tbl[6]  = r(1, 3, 1, 3, 0, 0, 1,   1, 0, 0, 0, 2);
    tbl[7]  = r(0, 0, 1, 2, 0, 0, 0,   1, 0, 0, 0, 3);
    tbl[8]  = r(0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 3);
    tbl[9]  = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 3);
    tbl[10] = r(0, 0, 0, 0, 0, 0, 0,   1, 1, 2, 0, 2);
    tbl[11] = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 2, 0, 2);
    tbl[12] = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 3, 0, 1);
    tbl[13] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[14] = r(1, 5, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[15] = r(1, 6, 0, 0, 0, 1, 1,   1, 0, 0, 0, 1);
    tbl[16] = r(0, 0, 1, 5, 1, 1, 0,   1, 0, 0, 0, 2);
    tbl[17] = r(0, 0, 1, 6, 0, 1, 0,   1, 0, 0, 0, 2);
    tbl[18] = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 6, 0, 1);
    tbl[19] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[20] = r(0, 0, 1, 9, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[21] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0);
    tbl[22] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[23] = r(1, 7, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
    tbl[24] = r(0, 0, 1, 7, 0, 0, 0,   1, 0, 0, 0, 1);
    tbl[25] = r(0, 0, 1, 7, 0, 0, 0,   1, 1, 7, 0, 1);
    tbl[26] = r(0, 0, 0, 0, 0, 0, 0,   1, 1, 7, 1, 1);
    tbl[27] = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 7, 0, 1);
    tbl[28] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    tbl[29] = r(1, 4, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    tbl[30] = r(1, 4, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1);
    tbl[31] = r(0, 0, 1, 4, 1, 0, 0,   1, 0, 0, 0, 2);
    tbl[32] = r(0, 0, 1, 4, 0, 1, 0,   1, 0, 0, 0, 2);
    tbl[33] = r(0, 0, 0, 0, 0, 1, 0,   1, 1, 4, 0, 1);
    tbl[34] = r(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);

    rst_n = 1'b0;
    issue_valid = 1'b0; issue_id = '0; issue_instr = '0; issue_rs = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; disp_ready = 1'b0;
    @(negedge ck);
    #1;
    chk("rst_issue_ready", 128'(issue_ready), 128'd0);
    chk("rst_disp_valid", 128'(disp_valid), 128'd0);
    chk("rst_commit_err", 128'(commit_err), 128'd0);
    chk("rst_occupancy", 128'(occupancy), 128'd0);
    @(negedge ck);
    rst_n = 1'b1;

    for (int v = 0; v < int'(NV); v++) begin
      drive(tbl[v].iv, tbl[v].iid, tbl[v].cv, tbl[v].cid, tbl[v].k, tbl[v].dr, tbl[v].push);
      chk($sformatf("vec%0d_issue_ready", v), 128'(issue_ready), 128'(tbl[v].e_rdy));
      chk($sformatf("vec%0d_disp_valid", v), 128'(disp_valid), 128'(tbl[v].e_dv));
      if (tbl[v].e_dv)
        chk($sformatf("vec%0d_disp_id", v), 128'(disp_id), 128'(tbl[v].e_did));
      chk($sformatf("vec%0d_commit_err", v), 128'(commit_err), 128'(tbl[v].e_err));
      chk($sformatf("vec%0d_occupancy", v), 128'(occupancy), 128'(tbl[v].e_occ));
      tick();
    end

    // Full buffer: no same-cycle bypass of the pop into issue_ready.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("full_issue_ready", 128'(issue_ready), 128'd0);
    chk("full_occupancy", 128'(occupancy), 128'd4);
    chk("full_disp_valid", 128'(disp_valid), 128'd1);
    tick();
    chk("full_reject_occ", 128'(occupancy), 128'd4);
    drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("pop_no_bypass_ready", 128'(issue_ready), 128'd0);
    tick();
    drive(1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    chk("after_pop_ready", 128'(issue_ready), 128'd1);
    chk("after_pop_occ", 128'(occupancy), 128'd3);
    tick();
    chk("refill_occ", 128'(occupancy), 128'd4);
    drain("full_drain");

    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 4'((rnd * 4 + i) % 16), 1'b1, 4'((rnd * 4 + i) % 16), 1'b0, 1'b0, 1'b1);
        tick();
      end
      chk($sformatf("wrap%0d_full_ready", rnd), 128'(issue_ready), 128'd0);
      chk($sformatf("wrap%0d_occ", rnd), 128'(occupancy), 128'd4);
      drain($sformatf("wrap%0d_drain", rnd));
    end

    // Reset with three buffered entries, the head already committed.
    drive(1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("prerst_disp_valid", 128'(disp_valid), 128'd1);
    chk("prerst_occ", 128'(occupancy), 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_disp_valid", 128'(disp_valid), 128'd0);
    chk("midrst_occ", 128'(occupancy), 128'd0);
    chk("midrst_issue_ready", 128'(issue_ready), 128'd0);
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("postrst%0d_disp_valid", c), 128'(disp_valid), 128'd0);
      tick();
    end
    drive(1'b0, 4'd0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("postrst_commit_err", 128'(commit_err), 128'd1);
    chk("postrst_occ", 128'(occupancy), 128'd0);
    tick();

    chk("scoreboard_empty", 128'(sbq.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
